ps2_direction_decoder: RTL and testbench
========================================

Name: ps2_direction_decoder

Overview:
- Converts the raw PS/2 scancode byte stream (ps2_key_pressed / ps2_out) into held-direction signals upSig/rightSig/downSig/leftSig.
- These feed the processor's virtual-memory direction read at address 4100, which yields 0 (none), 1 (up), 2 (right), 3 (down) or 4 (left).
- It tracks make/break codes, including E0-extended arrow keys, so a direction stays asserted for as long as its key is held.
- At most one direction output is high at any time, so the 4100 read always returns a defined code.

Parameters:
- WASD_EN, 1, when 1 the non-extended keys W(1D), D(23), S(1B), A(1C) alias up/right/down/left; when 0 they are ignored.
- PREFIX_TIMEOUT, 16'd50000, clock cycles a pending E0/F0 prefix may wait for its next byte before being discarded.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- ps2_key_pressed  input  1  byte-valid from the PS/2 receiver; may be held high for more than one cycle.
- ps2_out  input  8  received scancode byte, valid while ps2_key_pressed is high.
- upSig  output  1  up held and selected.
- rightSig  output  1  right held and selected.
- downSig  output  1  down held and selected.
- leftSig  output  1  left held and selected.
- dir_code  output  3  0 none, 1 up, 2 right, 3 down, 4 left; always consistent with the Sig outputs.
- key_event  output  1  one-cycle pulse when the held mask or dir_code changes.

Behaviour:
- Reset is synchronous and active-high. Reset clears the FSM to IDLE, held mask to 0000, last_dir to 0, timeout counter to 0, and all outputs to 0.
- Reset wins over a simultaneous byte. Reset mid-sequence (for example after E0) discards the prefix.

Byte acceptance:
- A byte is accepted on the cycle where ps2_key_pressed=1 and its registered previous value was 0 (rising-edge detect).
- A level held high yields exactly one byte.

FSM states and transitions (on each accepted byte b):
- IDLE:
  - b=E0 -> EXT.
  - b=F0 -> BRK.
  - b is a WASD code and WASD_EN=1 -> make(dir).
  - Any other byte -> ignored, stay IDLE.
- EXT:
  - b=F0 -> EXT_BRK.
  - b=75/74/72/6B -> make(up/right/down/left), go IDLE.
  - Any other byte -> IDLE, no change.
- BRK:
  - b is a WASD code and WASD_EN=1 -> break(dir).
  - In all cases go IDLE.
- EXT_BRK:
  - b is an arrow code -> break(dir).
  - In all cases go IDLE.

Prefix timeout:
- The counter runs while in EXT, BRK or EXT_BRK and clears on every accepted byte.
- When it reaches PREFIX_TIMEOUT-1 the FSM returns to IDLE with no mask change.

make(d):
- If d is not already held: set mask[d] and set last_dir=d.
- If d is already held (typematic repeat): no change, no key_event.

break(d):
- Clear mask[d].
- If d==last_dir, last_dir becomes the highest-priority remaining held key (up > right > down > left), or 0 if none remain.
- A break of a key that is not held produces no change.

Output selection:
- Outputs are registered. The one-hot output equals last_dir, and dir_code equals last_dir.
- Outputs update on the clock edge after the accepting edge, so latency is 1 cycle from acceptance of the final byte of a sequence.
- key_event is high for exactly that one cycle.

Arrow and WASD aliasing:
- Arrow and WASD keys for the same direction share one mask bit.
- Releasing either key clears that direction.

Test Plan:
1. Reset, then bytes E0,75 → upSig=1 and dir_code=1 one cycle after the 75 is accepted; key_event pulses once. Then E0,F0,75 → all Sig=0 and dir_code=0.
2. E0,74 (right) then E0,6B (left) → dir_code=4 with only leftSig high. Then E0,F0,6B → dir_code=2 (falls back to right).
3. ps2_key_pressed held high for 10 cycles with ps2_out=1D (WASD_EN=1) → exactly one make, upSig=1. Then F0,1D → upSig=0. Repeat with WASD_EN=0 → outputs stay 0.
4. Typematic repeat: E0,72 sent three times → downSig=1 after the first; key_event fires only once; no output glitch.
5. E0, then PREFIX_TIMEOUT idle cycles, then 75 → the 75 is treated as a bare byte in IDLE and ignored; outputs stay 0.
6. E0,75 (up held) then reset asserted on the same cycle as the next accepted byte E0 → all outputs 0 the next cycle. A following F0,75 → no change.

Source files
------------

// File: rtl/ps2_direction_decoder.sv
// ps2_direction_decoder: turns a PS/2 make/break scancode stream into held
// direction signals (arrow keys, optionally WASD), with a one-hot registered output.
`default_nettype none

module ps2_direction_decoder #(
  parameter bit          WASD_EN        = 1'b1,
  parameter logic [15:0] PREFIX_TIMEOUT = 16'd50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_out,
  output logic       upSig,
  output logic       rightSig,
  output logic       downSig,
  output logic       leftSig,
  output logic [2:0] dir_code,
  output logic       key_event
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        prev_q;
  logic [3:0]  mask_q, mask_d;
  logic [2:0]  last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        chg_q;
  logic [2:0]  dir_q;
  logic        ev_q;

  logic       accept;
  logic       wasd_v, arrow_v;
  logic [1:0] wasd_idx, arrow_idx;
  logic       mk, brk;
  logic [1:0] idx;
  logic [2:0] dir;

  assign accept = ps2_key_pressed & ~prev_q;

  // Mask bit index: 0 up, 1 right, 2 down, 3 left; direction code is index+1.
  always_comb begin
    wasd_v   = 1'b0;
    wasd_idx = 2'd0;
    case (ps2_out)
      8'h1D: begin wasd_v = WASD_EN; wasd_idx = 2'd0; end
      8'h23: begin wasd_v = WASD_EN; wasd_idx = 2'd1; end
      8'h1B: begin wasd_v = WASD_EN; wasd_idx = 2'd2; end
      8'h1C: begin wasd_v = WASD_EN; wasd_idx = 2'd3; end
      default: ;
    endcase
    arrow_v   = 1'b0;
    arrow_idx = 2'd0;
    case (ps2_out)
      8'h75: begin arrow_v = 1'b1; arrow_idx = 2'd0; end
      8'h74: begin arrow_v = 1'b1; arrow_idx = 2'd1; end
      8'h72: begin arrow_v = 1'b1; arrow_idx = 2'd2; end
      8'h6B: begin arrow_v = 1'b1; arrow_idx = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    mk      = 1'b0;
    brk     = 1'b0;
    idx     = 2'd0;
    if (accept) begin
      cnt_d = 16'd0;
      case (state_q)
        IDLE: begin
          if (ps2_out == 8'hE0)      state_d = EXT;
          else if (ps2_out == 8'hF0) state_d = BRK;
          else if (wasd_v) begin mk = 1'b1; idx = wasd_idx; end
        end
        EXT: begin
          if (ps2_out == 8'hF0) state_d = EXT_BRK;
          else begin
            state_d = IDLE;
            if (arrow_v) begin mk = 1'b1; idx = arrow_idx; end
          end
        end
        BRK: begin
          state_d = IDLE;
          if (wasd_v) begin brk = 1'b1; idx = wasd_idx; end
        end
        default: begin
          state_d = IDLE;
          if (arrow_v) begin brk = 1'b1; idx = arrow_idx; end
        end
      endcase
    end else if (state_q != IDLE) begin
      if (cnt_q == PREFIX_TIMEOUT - 16'd1) begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    dir = {1'b0, idx} + 3'd1;
    if (mk && !mask_q[idx]) begin
      mask_d[idx] = 1'b1;
      last_d      = dir;
    end
    // Releasing the shown direction falls back to the highest-priority key still held.
    if (brk && mask_q[idx]) begin
      mask_d[idx] = 1'b0;
      if (last_q == dir) begin
        if (mask_d[0])      last_d = 3'd1;
        else if (mask_d[1]) last_d = 3'd2;
        else if (mask_d[2]) last_d = 3'd3;
        else if (mask_d[3]) last_d = 3'd4;
        else                last_d = 3'd0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      mask_q  <= 4'd0;
      last_q  <= 3'd0;
      cnt_q   <= 16'd0;
      chg_q   <= 1'b0;
      dir_q   <= 3'd0;
      ev_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= ps2_key_pressed;
      mask_q  <= mask_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      chg_q   <= (mask_d != mask_q) || (last_d != last_q);
      dir_q   <= last_q;
      ev_q    <= chg_q;
    end
  end

  assign dir_code  = dir_q;
  assign key_event = ev_q;
  assign upSig     = (dir_q == 3'd1);
  assign rightSig  = (dir_q == 3'd2);
  assign downSig   = (dir_q == 3'd3);
  assign leftSig   = (dir_q == 3'd4);

endmodule

`default_nettype wire

// File: tb/tb_ps2_direction_decoder.sv
// Bench for ps2_direction_decoder: directed byte sequences, expected direction
// codes queued per key_event and checked when the event pulse appears.
`default_nettype none

module tb_ps2_direction_decoder;

  localparam logic [15:0] TMO = 16'd64;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2_key_pressed;
  logic [7:0] ps2_out;
  logic       up, right, down, left, ev;
  logic [2:0] code;
  logic       up2, right2, down2, left2, ev2;
  logic [2:0] code2;

  int errors = 0;
  int checks = 0;
  int nw_events = 0;
  logic [2:0] exp_q[$];

  always #5 clock = ~clock;

  ps2_direction_decoder #(.WASD_EN(1'b1), .PREFIX_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .ps2_key_pressed(ps2_key_pressed), .ps2_out(ps2_out),
    .upSig(up), .rightSig(right), .downSig(down), .leftSig(left),
    .dir_code(code), .key_event(ev)
  );

  ps2_direction_decoder #(.WASD_EN(1'b0), .PREFIX_TIMEOUT(TMO)) dut_nw (
    .clock(clock), .reset(reset), .ps2_key_pressed(ps2_key_pressed), .ps2_out(ps2_out),
    .upSig(up2), .rightSig(right2), .downSig(down2), .leftSig(left2),
    .dir_code(code2), .key_event(ev2)
  );

  function automatic logic [3:0] onehot(input logic [2:0] c);
    case (c)
      3'd1: onehot = 4'b0001;
      3'd2: onehot = 4'b0010;
      3'd3: onehot = 4'b0100;
      3'd4: onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: each key_event pulse must match the next queued code.
  logic [2:0] popped;
  always @(negedge clock) begin
    if (ev2) nw_events++;
    if (ev) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_event: observed=dir_code %0d expected=no event", code);
      end
      if (exp_q.size() != 0) begin
        popped = exp_q.pop_front();
        check("event_dir_code", {5'd0, code}, {5'd0, popped});
        check("event_onehot", {4'd0, left, down, right, up}, {4'd0, onehot(popped)});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    ps2_out = b;
    ps2_key_pressed = 1'b1;
    @(negedge clock);
    ps2_key_pressed = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [2:0] exp);
    check(tag, {5'd0, code}, {5'd0, exp});
    check({tag, "_sig"}, {4'd0, left, down, right, up}, {4'd0, onehot(exp)});
  endtask

  task automatic drain(input string tag);
    idle(3);
    check({tag, "_queue_empty"}, 8'(exp_q.size()), 8'd0);
  endtask

  initial begin
    reset = 1'b1;
    ps2_key_pressed = 1'b0;
    ps2_out = 8'h00;
    idle(3);
    check_state("reset", 3'd0);
    check("reset_event", {7'd0, ev}, 8'd0);
    reset = 1'b0;
    idle(2);

    // 1: up via arrow with exact one-cycle output latency, then release
    send(8'hE0);
    exp_q.push_back(3'd1);
    @(negedge clock);
    ps2_out = 8'h75;
    ps2_key_pressed = 1'b1;
    @(negedge clock);
    ps2_key_pressed = 1'b0;
    @(negedge clock);
    check("t1_latency_up", {7'd0, up}, 8'd1);
    check("t1_latency_ev", {7'd0, ev}, 8'd1);
    idle(2);
    check_state("t1_up", 3'd1);
    exp_q.push_back(3'd0);
    send(8'hE0); send(8'hF0); send(8'h75);
    check_state("t1_release", 3'd0);
    drain("t1");

    // 2: right then left, release left falls back to right
    exp_q.push_back(3'd2);
    send(8'hE0); send(8'h74);
    exp_q.push_back(3'd4);
    send(8'hE0); send(8'h6B);
    check_state("t2_left", 3'd4);
    exp_q.push_back(3'd2);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check_state("t2_fallback", 3'd2);
    // mask-only change: releasing a non-shown key still pulses key_event
    exp_q.push_back(3'd1);
    send(8'hE0); send(8'h75);
    exp_q.push_back(3'd1);
    send(8'hE0); send(8'hF0); send(8'h74);
    check_state("t2_keep_up", 3'd1);
    exp_q.push_back(3'd0);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain("t2");

    // 3: held level yields one WASD make; WASD_EN=0 instance ignores it
    do_reset();
    nw_events = 0;
    exp_q.push_back(3'd1);
    @(negedge clock);
    ps2_out = 8'h1D;
    ps2_key_pressed = 1'b1;
    idle(10);
    ps2_key_pressed = 1'b0;
    idle(2);
    check_state("t3_w_up", 3'd1);
    check("t3_nw_code", {5'd0, code2}, 8'd0);
    check("t3_nw_sig", {4'd0, left2, down2, right2, up2}, 8'd0);
    exp_q.push_back(3'd0);
    send(8'hF0); send(8'h1D);
    check_state("t3_w_release", 3'd0);
    // arrow and W share the up bit
    exp_q.push_back(3'd1);
    send(8'h1D);
    exp_q.push_back(3'd0);
    send(8'hE0); send(8'hF0); send(8'h75);
    check_state("t3_alias_release", 3'd0);
    check("t3_nw_events", 8'(nw_events), 8'd0);
    drain("t3");

    // 4: typematic repeat of down produces a single event
    exp_q.push_back(3'd3);
    for (int i = 0; i < 3; i++) begin
      send(8'hE0); send(8'h72);
    end
    check_state("t4_down", 3'd3);
    exp_q.push_back(3'd0);
    send(8'hE0); send(8'hF0); send(8'h72);
    drain("t4");

    // 5: stale E0 prefix times out; a fresh prefix inside the window still works
    send(8'hE0);
    idle(int'(TMO) + 16);
    send(8'h75);
    check_state("t5_timeout_ignored", 3'd0);
    exp_q.push_back(3'd1);
    send(8'hE0);
    idle(int'(TMO) / 2);
    send(8'h75);
    check_state("t5_in_window", 3'd1);
    exp_q.push_back(3'd0);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain("t5");

    // 6: reset coinciding with an accepted E0 discards everything
    exp_q.push_back(3'd1);
    send(8'hE0); send(8'h75);
    drain("t6_pre");
    @(negedge clock);
    ps2_out = 8'hE0;
    ps2_key_pressed = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    ps2_key_pressed = 1'b0;
    reset = 1'b0;
    check_state("t6_reset", 3'd0);
    send(8'hF0); send(8'h75);
    check_state("t6_no_change", 3'd0);
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
